uart_fetch_arbiter: RTL and testbench

- Owns the read side (tail pointer) of the 64-entry UART instruction buffer RAM.
- Shares that buffer between N_REQ instruction-fetch requesters (render cores) using round-robin arbitration.
- Sequences each RAM read and returns the word over a valid/ready handshake.
- If the buffer stays empty too long, returns a NOP so requesters never deadlock.

---
 rtl/uart_fetch_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/uart_fetch_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_fetch_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fetch_pkg.sv
// Shared constants and FSM encoding for the UART instruction-buffer fetch arbiter.
package uart_fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] SPIN_INSTR = 32'hfa9e_f06f;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_PTR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [RR_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first;

    // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = N_REQ'({req, req} >> rr_ptr);
        first = rot & (~rot + N_REQ'(1));
        grant = N_REQ'(({first, first} << rr_ptr) >> N_REQ);
    end

endmodule

// File: rtl/uart_fetch_arbiter.sv
// Read side of the UART instruction buffer: arbitrates fetch requesters, sequences
// the registered RAM read and returns a word (or a NOP after a long empty stall).
//
// state | meaning
// IDLE  | wait for a request; count empty-buffer stall cycles
// READ  | RAM address presented, waiting out the read latency
// FILL  | capture ram_q into the response register
// RESP  | resp_valid[gnt] held until resp_ready[gnt]
module uart_fetch_arbiter
    import uart_fetch_pkg::*;
#(
    parameter int          N_REQ       = 2,
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          PTR_W       = DEF_PTR_W,
    parameter int          STALL_LIMIT = 16,
    parameter logic [31:0] NOP_INSTR   = uart_fetch_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ-1:0]  resp_ready,
    output logic [N_REQ-1:0]  resp_valid,
    output logic [31:0]       resp_instr,
    output logic              resp_is_nop,
    input  logic              flush,
    input  logic [PTR_W-1:0]  head,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [31:0]       ram_q,
    output logic [PTR_W:0]    occupancy
);

    localparam int RR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    fetch_state_e       state_q, state_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]    gnt_q, gnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [31:0]        resp_instr_q, resp_instr_d;
    logic               resp_is_nop_q, resp_is_nop_d;
    logic [PTR_W:0]     occupancy_q, occupancy_d;

    logic [N_REQ-1:0]   grant_oh;
    logic [RR_W-1:0]    grant_idx;
    logic               empty;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .RR_W  (RR_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant_oh)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) grant_idx = RR_W'(i);
        end
    end

    assign empty = (head == tail_q);

    always_comb begin
        state_d       = state_q;
        tail_d        = tail_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        stall_cnt_d   = stall_cnt_q;
        resp_valid_d  = resp_valid_q;
        resp_instr_d  = resp_instr_q;
        resp_is_nop_d = resp_is_nop_q;
        occupancy_d   = {1'b0, head - tail_q};

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d = grant_idx;
                    if (!empty) begin
                        state_d     = READ;
                        stall_cnt_d = '0;
                    end else if (stall_cnt_q == STALL_W'(STALL_LIMIT - 1)) begin
                        state_d       = RESP;
                        resp_instr_d  = NOP_INSTR;
                        resp_is_nop_d = 1'b1;
                        resp_valid_d  = grant_oh;
                        stall_cnt_d   = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    end
                end else begin
                    stall_cnt_d = '0;
                end
            end
            READ: state_d = FILL;
            FILL: begin
                resp_instr_d  = ram_q;
                resp_is_nop_d = 1'b0;
                resp_valid_d  = N_REQ'(1) << gnt_q;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready[gnt_q]) begin
                    resp_valid_d = '0;
                    if (!resp_is_nop_q) tail_d = tail_q + PTR_W'(1);
                    rr_ptr_d = (gnt_q == RR_W'(N_REQ - 1)) ? '0 : gnt_q + RR_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush in the handshake cycle counts as delivery; the arbiter keeps its place.
        if (flush) begin
            tail_d       = head;
            resp_valid_d = '0;
            state_d      = IDLE;
            stall_cnt_d  = '0;
            rr_ptr_d     = rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tail_q        <= '0;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            stall_cnt_q   <= '0;
            resp_valid_q  <= '0;
            resp_instr_q  <= NOP_INSTR;
            resp_is_nop_q <= 1'b0;
            occupancy_q   <= '0;
        end else begin
            state_q       <= state_d;
            tail_q        <= tail_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            stall_cnt_q   <= stall_cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_instr_q  <= resp_instr_d;
            resp_is_nop_q <= resp_is_nop_d;
            occupancy_q   <= occupancy_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_instr    = resp_instr_q;
    assign resp_is_nop   = resp_is_nop_q;
    assign ram_rdaddress = tail_q[ADDR_W-1:0];
    assign occupancy     = occupancy_q;

endmodule

// File: tb/tb_uart_fetch_arbiter.sv
// Self-checking bench for uart_fetch_arbiter with a behavioural RAM and fetch model.
module tb_uart_fetch_arbiter;

    localparam int N = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, resp_ready, resp_valid;
    logic [31:0] resp_instr, ram_q;
    logic        resp_is_nop, flush;
    logic [7:0]  head;
    logic [5:0]  ram_rdaddress;
    logic [8:0]  occupancy;
    logic [31:0] ram [64];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1:0]  obs_v [$];
    logic [31:0] obs_i [$];
    logic        obs_n [$];
    int          obs_c [$];

    uart_fetch_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .resp_ready    (resp_ready),
        .resp_valid    (resp_valid),
        .resp_instr    (resp_instr),
        .resp_is_nop   (resp_is_nop),
        .flush         (flush),
        .head          (head),
        .ram_rdaddress (ram_rdaddress),
        .ram_q         (ram_q),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= ram[ram_rdaddress];
    always @(posedge clk) cyc <= cyc + 1;

    // Record each response that will be accepted at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && flush === 1'b0 && (resp_valid & resp_ready) != 2'b00) begin
            obs_v.push_back(resp_valid);
            obs_i.push_back(resp_instr);
            obs_n.push_back(resp_is_nop);
            obs_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int pick(input logic [1:0] r, input int rr);
        for (int k = 0; k < N; k++) begin
            if (r[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        flush = 1'b0;
        head = 8'h00;
        settle(3);
        rst_n = 1'b1;
        settle(2);
        obs_v.delete();
        obs_i.delete();
        obs_n.delete();
        obs_c.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b want 00", resp_valid); end
        total++; if (resp_instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", resp_instr, NOP); end
        total++; if (resp_is_nop !== 1'b0) begin bad++; $display("FAIL reset_nop: got %b want 0", resp_is_nop); end
        total++; if (ram_rdaddress !== 6'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", ram_rdaddress); end
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_single();
        int c0;
        apply_reset();
        for (int i = 0; i < 3; i++) ram[i] = $urandom;
        head = 8'd3;
        settle(2);
        c0 = cyc;
        req_valid = 2'b01;
        resp_ready = 2'b01;
        for (int c = 0; c < 60 && obs_i.size() < 3; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 3) begin bad++; $display("FAIL single_count: got %0d want 3", obs_i.size()); end
        for (int k = 0; k < 3 && k < obs_i.size(); k++) begin
            total++; if (obs_v[k] !== 2'b01) begin bad++; $display("FAIL single_valid[%0d]: got %b want 01", k, obs_v[k]); end
            total++; if (obs_i[k] !== ram[k]) begin bad++; $display("FAIL single_instr[%0d]: got %h want %h", k, obs_i[k], ram[k]); end
            total++; if (obs_n[k] !== 1'b0) begin bad++; $display("FAIL single_nop[%0d]: got %b want 0", k, obs_n[k]); end
            total++; if (obs_c[k] != c0 + 3 + 4 * k) begin bad++; $display("FAIL single_latency[%0d]: got cycle %0d want %0d", k, obs_c[k], c0 + 3 + 4 * k); end
        end
        settle(20);
        total++; if (ram_rdaddress !== 6'd3) begin bad++; $display("FAIL single_tail: got %0d want 3", ram_rdaddress); end
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL single_occ: got %0d want 0", occupancy); end
        total++; if (obs_i.size() != 3) begin bad++; $display("FAIL single_extra: got %0d responses want 3", obs_i.size()); end
    endtask

    task automatic test_round_robin();
        int pending [2];
        int rr, idx, nwords, g;
        logic [1:0] exp_v;
        for (int it = 0; it < 5; it++) begin
            apply_reset();
            if (it == 0) begin
                pending[0] = 2; pending[1] = 2;
            end else begin
                pending[0] = $urandom_range(1, 4); pending[1] = $urandom_range(0, 4);
            end
            nwords = pending[0] + pending[1];
            for (int i = 0; i < nwords; i++) ram[i] = $urandom;
            head = 8'(nwords);
            rr = 0;
            idx = 0;
            req_valid = {pending[1] > 0, pending[0] > 0};
            for (int c = 0; c < 400 && idx < nwords; c++) begin
                @(posedge clk);
                #2;
                resp_ready = (it == 0) ? 2'b11 : 2'($urandom_range(0, 3));
                @(negedge clk);
                #1;
                while (idx < obs_i.size()) begin
                    g = pick({pending[1] > 0, pending[0] > 0}, rr);
                    exp_v = (g < 0) ? 2'b00 : (2'b01 << g);
                    total++; if (obs_v[idx] !== exp_v) begin bad++; $display("FAIL rr_grant[%0d.%0d]: got %b want %b", it, idx, obs_v[idx], exp_v); end
                    total++; if (obs_i[idx] !== ram[idx]) begin bad++; $display("FAIL rr_instr[%0d.%0d]: got %h want %h", it, idx, obs_i[idx], ram[idx]); end
                    total++; if (obs_n[idx] !== 1'b0) begin bad++; $display("FAIL rr_nop[%0d.%0d]: got %b want 0", it, idx, obs_n[idx]); end
                    if (g >= 0) begin
                        pending[g] = pending[g] - 1;
                        rr = (g + 1) % N;
                    end
                    idx++;
                end
                req_valid = {pending[1] > 0, pending[0] > 0};
            end
            req_valid = 2'b00;
            total++; if (idx != nwords) begin bad++; $display("FAIL rr_count[%0d]: got %0d want %0d", it, idx, nwords); end
            settle(3);
            total++; if (ram_rdaddress !== 6'(nwords)) begin bad++; $display("FAIL rr_tail[%0d]: got %0d want %0d", it, ram_rdaddress, nwords); end
            total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL rr_occ[%0d]: got %0d want 0", it, occupancy); end
        end
    endtask

    task automatic test_stall_nop();
        int c0;
        apply_reset();
        c0 = cyc;
        req_valid = 2'b10;
        resp_ready = 2'b11;
        for (int c = 0; c < 40 && obs_i.size() < 1; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 1) begin bad++; $display("FAIL nop_count: got %0d want 1", obs_i.size()); end
        if (obs_i.size() > 0) begin
            total++; if (obs_v[0] !== 2'b10) begin bad++; $display("FAIL nop_valid: got %b want 10", obs_v[0]); end
            total++; if (obs_i[0] !== NOP) begin bad++; $display("FAIL nop_instr: got %h want %h", obs_i[0], NOP); end
            total++; if (obs_n[0] !== 1'b1) begin bad++; $display("FAIL nop_flag: got %b want 1", obs_n[0]); end
            total++; if (obs_c[0] != c0 + 16) begin bad++; $display("FAIL nop_latency: got cycle %0d want %0d", obs_c[0], c0 + 16); end
        end
        settle(3);
        total++; if (ram_rdaddress !== 6'd0) begin bad++; $display("FAIL nop_tail: got %0d want 0", ram_rdaddress); end
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL nop_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 3; i++) ram[i] = $urandom;
        head = 8'd2;
        req_valid = 2'b01;
        resp_ready = 2'b00;
        for (int c = 0; c < 20 && resp_valid == 2'b00; c++) settle(1);
        total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL flush_wait: got %b want 01", resp_valid); end
        for (int c = 0; c < 10; c++) begin
            settle(1);
            total++; if (resp_valid !== 2'b01 || resp_instr !== ram[0]) begin bad++; $display("FAIL flush_hold[%0d]: got %b/%h want 01/%h", c, resp_valid, resp_instr, ram[0]); end
        end
        flush = 1'b1;
        resp_ready = 2'b01;
        settle(1);
        flush = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL flush_valid: got %b want 00", resp_valid); end
        total++; if (ram_rdaddress !== 6'd2) begin bad++; $display("FAIL flush_tail: got %0d want 2", ram_rdaddress); end
        settle(1);
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        settle(20);
        total++; if (obs_i.size() != 0) begin bad++; $display("FAIL flush_noresp: got %0d responses want 0", obs_i.size()); end
        head = 8'd3;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        for (int c = 0; c < 20 && obs_i.size() < 1; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 1) begin bad++; $display("FAIL flush_next_count: got %0d want 1", obs_i.size()); end
        if (obs_i.size() > 0) begin
            total++; if (obs_v[0] !== 2'b01) begin bad++; $display("FAIL flush_rr: got %b want 01", obs_v[0]); end
            total++; if (obs_i[0] !== ram[2]) begin bad++; $display("FAIL flush_next_instr: got %h want %h", obs_i[0], ram[2]); end
        end
        settle(3);
    endtask

    task automatic test_wrap();
        int addr [4];
        addr[0] = 62; addr[1] = 63; addr[2] = 0; addr[3] = 1;
        apply_reset();
        head = 8'hFE;
        settle(1);
        flush = 1'b1;
        settle(1);
        flush = 1'b0;
        for (int k = 0; k < 4; k++) ram[addr[k]] = $urandom;
        head = 8'h02;
        settle(2);
        total++; if (occupancy !== 9'd4) begin bad++; $display("FAIL wrap_occ_pre: got %0d want 4", occupancy); end
        total++; if (ram_rdaddress !== 6'd62) begin bad++; $display("FAIL wrap_addr_pre: got %0d want 62", ram_rdaddress); end
        req_valid = 2'b01;
        resp_ready = 2'b01;
        for (int c = 0; c < 60 && obs_i.size() < 4; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", obs_i.size()); end
        for (int k = 0; k < 4 && k < obs_i.size(); k++) begin
            total++; if (obs_i[k] !== ram[addr[k]]) begin bad++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, obs_i[k], ram[addr[k]]); end
        end
        settle(3);
        total++; if (ram_rdaddress !== 6'd2) begin bad++; $display("FAIL wrap_tail: got %0d want 2", ram_rdaddress); end
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL wrap_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_full();
        apply_reset();
        ram[0] = $urandom;
        head = 8'd64;
        settle(2);
        total++; if (occupancy !== 9'd64) begin bad++; $display("FAIL full_occ: got %0d want 64", occupancy); end
        req_valid = 2'b01;
        resp_ready = 2'b01;
        for (int c = 0; c < 20 && obs_i.size() < 1; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 1 || obs_i[0] !== ram[0]) begin bad++; $display("FAIL full_instr: got %0d responses first %h want 1 of %h", obs_i.size(), (obs_i.size() > 0) ? obs_i[0] : 32'h0, ram[0]); end
        settle(3);
        total++; if (occupancy !== 9'd63) begin bad++; $display("FAIL full_occ_after: got %0d want 63", occupancy); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) ram[i] = $urandom;
        head = 8'd3;
        req_valid = 2'b01;
        resp_ready = 2'b01;
        for (int c = 0; c < 20 && obs_i.size() < 1; c++) settle(1);
        total++; if (obs_i.size() != 1) begin bad++; $display("FAIL mid_first: got %0d want 1", obs_i.size()); end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        head = 8'd0;
        req_valid = 2'b00;
        #1;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL mid_valid: got %b want 00", resp_valid); end
        total++; if (resp_instr !== NOP) begin bad++; $display("FAIL mid_instr: got %h want %h", resp_instr, NOP); end
        total++; if (resp_is_nop !== 1'b0) begin bad++; $display("FAIL mid_nop: got %b want 0", resp_is_nop); end
        total++; if (ram_rdaddress !== 6'd0) begin bad++; $display("FAIL mid_addr: got %0d want 0", ram_rdaddress); end
        total++; if (occupancy !== 9'd0) begin bad++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
        settle(2);
        rst_n = 1'b1;
        obs_i.delete(); obs_v.delete(); obs_n.delete(); obs_c.delete();
        settle(25);
        total++; if (obs_i.size() != 0) begin bad++; $display("FAIL mid_noresp: got %0d responses want 0", obs_i.size()); end
        head = 8'd3;
        req_valid = 2'b01;
        for (int c = 0; c < 20 && obs_i.size() < 1; c++) settle(1);
        req_valid = 2'b00;
        total++; if (obs_i.size() != 1 || obs_i[0] !== ram[0]) begin bad++; $display("FAIL mid_restart: got %0d responses first %h want 1 of %h", obs_i.size(), (obs_i.size() > 0) ? obs_i[0] : 32'h0, ram[0]); end
        settle(3);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        rst_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        flush = 1'b0;
        head = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_stall_nop();
        test_flush();
        test_wrap();
        test_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
